// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_master
// Purpose  : Bridges a byte-stream UART to a simple register bus. Frames are
//            a command byte (0x57 write / 0x52 read) followed by a 4-byte
//            big-endian address and, for writes, a 4-byte big-endian data
//            word. A write is acknowledged with 0x4B, a read returns the
//            4 read-data bytes MSB first, an unknown command returns 0x3F.
//            A stalled frame (no byte for TIMEOUT_CYCLES) is silently dropped.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            rx_data/valid/ready - inbound byte stream (valid/ready handshake)
//            tx_data/valid/ready - outbound response bytes
//            bus_addr            - registered bus address
//            bus_wr_data         - registered bus write data
//            bus_wr_en           - one-cycle write strobe
//            bus_rd_en           - one-cycle read strobe
//            bus_rd_data         - read data, valid the cycle after bus_rd_en
//            busy                - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  output logic                  bus_wr_en,
  output logic                  bus_rd_en,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  output logic                  busy
);

  localparam logic [7:0] c_CMD_WRITE = 8'h57;
  localparam logic [7:0] c_CMD_READ  = 8'h52;
  localparam logic [7:0] c_RESP_ERR  = 8'h3F;
  localparam logic [7:0] c_RESP_ACK  = 8'h4B;

  localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    BUS_WR  = 3'd3,
    BUS_RD  = 3'd4,
    RD_WAIT = 3'd5,
    TX_RESP = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_byte_cnt;
  logic                  r_is_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp;
  logic [1:0]            r_resp_cnt;   // response bytes remaining minus one
  logic [c_TMO_W-1:0]    r_tmo_cnt;

  logic w_rx_fire;
  logic w_tx_fire;
  logic w_cmd_valid;
  logic w_timeout;

  assign rx_ready    = (r_state == IDLE) || (r_state == ADDR) || (r_state == DATA);
  assign tx_valid    = (r_state == TX_RESP);
  assign bus_wr_en   = (r_state == BUS_WR);
  assign bus_rd_en   = (r_state == BUS_RD);
  assign busy        = (r_state != IDLE);
  assign tx_data     = r_resp[DATA_WIDTH-1 -: 8];
  assign bus_addr    = r_addr;
  assign bus_wr_data = r_wdata;

  assign w_rx_fire   = rx_valid && rx_ready;
  assign w_tx_fire   = tx_valid && tx_ready;
  assign w_cmd_valid = (rx_data == c_CMD_WRITE) || (rx_data == c_CMD_READ);
  // An arriving byte always wins over an expiring timeout in the same cycle.
  assign w_timeout   = (r_tmo_cnt == c_TMO_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          w_state_next = w_cmd_valid ? ADDR : TX_RESP;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          if (r_byte_cnt == 2'd3) begin
            w_state_next = r_is_write ? DATA : BUS_RD;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          if (r_byte_cnt == 2'd3) begin
            w_state_next = BUS_WR;
          end
        end else if (w_timeout) begin
          w_state_next = IDLE;
        end
      end
      BUS_WR:  w_state_next = TX_RESP;
      BUS_RD:  w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = TX_RESP;
      TX_RESP: begin
        if (tx_ready && (r_resp_cnt == 2'd0)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift registers, response buffer, counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_resp     <= '0;
      r_resp_cnt <= 2'd0;
      r_tmo_cnt  <= '0;
    end else begin
      // Idle-gap counter only runs while a frame is being received.
      if (((r_state == ADDR) || (r_state == DATA)) && !w_rx_fire) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end

      case (r_state)
        IDLE: begin
          if (w_rx_fire) begin
            r_byte_cnt <= 2'd0;
            r_is_write <= (rx_data == c_CMD_WRITE);
            if (!w_cmd_valid) begin
              r_resp     <= {c_RESP_ERR, {(DATA_WIDTH-8){1'b0}}};
              r_resp_cnt <= 2'd0;
            end
          end
        end
        ADDR: begin
          if (w_rx_fire) begin
            r_addr     <= {r_addr[ADDR_WIDTH-9:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_rx_fire) begin
            r_wdata    <= {r_wdata[DATA_WIDTH-9:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        BUS_WR: begin
          r_resp     <= {c_RESP_ACK, {(DATA_WIDTH-8){1'b0}}};
          r_resp_cnt <= 2'd0;
        end
        RD_WAIT: begin
          r_resp     <= bus_rd_data;
          r_resp_cnt <= 2'd3;
        end
        TX_RESP: begin
          // Response is sent MSB first by shifting the next byte to the top.
          if (w_tx_fire) begin
            r_resp     <= {r_resp[DATA_WIDTH-9:0], 8'h00};
            r_resp_cnt <= r_resp_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_bus_master
// Purpose  : Self-checking bench for uart_bus_master. Frames are sent as byte
//            streams; expected bus accesses and response bytes come from a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic          bus_wr_en;
  logic          bus_rd_en;
  logic [DW-1:0] bus_rd_data;
  logic          busy;

  always #5 clk = ~clk;

  uart_bus_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bus_addr   (bus_addr),
    .bus_wr_data(bus_wr_data),
    .bus_wr_en  (bus_wr_en),
    .bus_rd_en  (bus_rd_en),
    .bus_rd_data(bus_rd_data),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  int   cyc         = 0;
  int   last_rx_cyc = 0;
  int   wr_cyc      = 0;
  int   rd_cyc      = 0;
  int   txv_cyc     = 0;
  logic txv_q       = 1'b0;

  logic [63:0] wr_log[$];
  logic [31:0] rd_log[$];
  logic [7:0]  tx_log[$];

  // Reference-model view of the registered bus outputs.
  logic [31:0] model_addr = 32'h0;
  logic [31:0] model_data = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event monitor: records every handshake and strobe with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) last_rx_cyc <= cyc;
    if (bus_wr_en) begin
      wr_log.push_back({bus_addr, bus_wr_data});
      wr_cyc <= cyc;
    end
    if (bus_rd_en) begin
      rd_log.push_back(bus_addr);
      rd_cyc <= cyc;
    end
    if (tx_valid && !txv_q) txv_cyc <= cyc;
    txv_q <= tx_valid;
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    if (bus_wr_en || bus_rd_en) check("strobe_exclusive", 64'(bus_wr_en && bus_rd_en), 64'd0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n        = 0;
    acc      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) check("rx_ready_wait", 64'd0, 64'd1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic recv_bytes(input int nbytes, input int first_stall);
    int         w;
    int         stall;
    logic [7:0] held;
    logic       ok;
    for (int i = 0; i < nbytes; i++) begin
      w = 0;
      while (!tx_valid && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!tx_valid) begin
        check("tx_valid_wait", 64'd0, 64'd1);
        return;
      end
      stall    = (i == 0) ? first_stall : int'($urandom_range(0, 2));
      held     = tx_data;
      ok       = 1'b1;
      tx_ready = 1'b0;
      repeat (stall) begin
        @(posedge clk);
        #1;
        if (!tx_valid || tx_data !== held) ok = 1'b0;
      end
      if (stall > 0) check("tx_hold", 64'(ok), 64'd1);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdv,
                           input int first_stall, input string tag);
    logic [7:0] exp_tx[$];
    logic       is_wr;
    logic       is_rd;
    is_wr = (cmd == 8'h57);
    is_rd = (cmd == 8'h52);
    wr_log.delete();
    rd_log.delete();
    tx_log.delete();
    exp_tx.delete();
    bus_rd_data = rdv;

    send_byte(cmd);
    if (is_wr || is_rd) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 2));
        send_byte(addr[31-8*i -: 8]);
      end
    end
    if (is_wr) begin
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 2));
        send_byte(data[31-8*i -: 8]);
      end
    end

    // Frame-level reference outcome.
    if (is_wr) begin
      exp_tx.push_back(8'h4B);
      model_addr = addr;
      model_data = data;
    end else if (is_rd) begin
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rdv >> (24 - 8*i)));
      model_addr = addr;
    end else begin
      exp_tx.push_back(8'h3F);
    end

    recv_bytes(exp_tx.size(), first_stall);
    idle(2);

    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_tx_count"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      check({tag, "_tx_byte"}, 64'(tx_log[i]), 64'(exp_tx[i]));
    check({tag, "_wr_count"}, 64'(wr_log.size()), is_wr ? 64'd1 : 64'd0);
    check({tag, "_rd_count"}, 64'(rd_log.size()), is_rd ? 64'd1 : 64'd0);
    if (is_wr && wr_log.size() > 0) begin
      check({tag, "_wr_access"}, wr_log[0], {addr, data});
      check({tag, "_wr_latency"}, 64'(wr_cyc - last_rx_cyc), 64'd1);
      check({tag, "_wr_tx_latency"}, 64'(txv_cyc - last_rx_cyc), 64'd2);
    end
    if (is_rd && rd_log.size() > 0) begin
      check({tag, "_rd_addr"}, 64'(rd_log[0]), 64'(addr));
      check({tag, "_rd_latency"}, 64'(rd_cyc - last_rx_cyc), 64'd1);
      check({tag, "_rd_tx_latency"}, 64'(txv_cyc - last_rx_cyc), 64'd3);
    end
    check({tag, "_addr_hold"}, 64'(bus_addr), 64'(model_addr));
    check({tag, "_data_hold"}, 64'(bus_wr_data), 64'(model_data));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         r;
    logic [7:0] cmd;

    rst         = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    tx_ready    = 1'b0;
    bus_rd_data = '0;
    idle(3);
    rst = 1'b0;

    // Reset values
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wr_en", 64'(bus_wr_en), 64'd0);
    check("rst_rd_en", 64'(bus_rd_en), 64'd0);
    check("rst_addr", 64'(bus_addr), 64'd0);
    check("rst_wdata", 64'(bus_wr_data), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);

    // Directed write and read
    run_frame(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, "wr_directed");
    run_frame(8'h52, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, "rd_directed");

    // Invalid command followed by a normal write
    run_frame(8'hAA, 32'h0, 32'h0, 32'h0, 0, "invalid_aa");
    run_frame(8'h57, $urandom, $urandom, 32'h0, 1, "wr_after_inv");

    // Long tx back-pressure on a read response (longer than the timeout)
    run_frame(8'h52, $urandom, 32'h0, $urandom, 20, "rd_stall");

    // Randomized mix of frames
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0) cmd = 8'h57;
      else if (r == 1) cmd = 8'h52;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
      end
      run_frame(cmd, $urandom, $urandom, $urandom, $urandom_range(0, 4), "rand");
    end

    // Timeout: partial frame then silence
    wr_log.delete();
    rd_log.delete();
    tx_log.delete();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_cycles", 64'(k), 64'(TMO));
    idle(5);
    check("tmo_no_wr", 64'(wr_log.size()), 64'd0);
    check("tmo_no_rd", 64'(rd_log.size()), 64'd0);
    check("tmo_no_tx", 64'(tx_log.size()), 64'd0);
    run_frame(8'h57, $urandom, $urandom, 32'h0, 0, "wr_after_tmo");

    // Reset during the 2nd data byte of a write
    wr_log.delete();
    tx_log.delete();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'hDE);
    rx_valid = 1'b1;
    rx_data  = 8'hAD;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_wr_en", 64'(bus_wr_en), 64'd0);
    check("mid_rst_rd_en", 64'(bus_rd_en), 64'd0);
    check("mid_rst_addr", 64'(bus_addr), 64'd0);
    check("mid_rst_wdata", 64'(bus_wr_data), 64'd0);
    check("mid_rst_tx_data", 64'(tx_data), 64'd0);
    check("mid_rst_rx_ready", 64'(rx_ready), 64'd1);
    rst = 1'b0;
    idle(20);
    check("mid_rst_no_wr", 64'(wr_log.size()), 64'd0);
    check("mid_rst_no_tx", 64'(tx_log.size()), 64'd0);
    model_addr = 32'h0;
    model_data = 32'h0;
    run_frame(8'hC3, 32'h0, 32'h0, 32'h0, 0, "inv_after_rst");
    run_frame(8'h57, $urandom, $urandom, 32'h0, 2, "wr_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, bus address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, bus data width in bits, fixed at 4 bytes.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum idle cycles between bytes inside a frame.
REQ-004 The block SHALL have ports, in this order:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte from UART
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  block accepts rx_data this cycle
- tx_data  output  8  response byte to UART
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  UART accepts tx_data this cycle
- bus_addr  output  ADDR_WIDTH  bus address
- bus_wr_data  output  DATA_WIDTH  bus write data
- bus_wr_en  output  1  one-cycle write strobe
- bus_rd_en  output  1  one-cycle read strobe
- bus_rd_data  input  DATA_WIDTH  read data, valid the cycle after bus_rd_en
- busy  output  1  high in any state other than IDLE

Function
REQ-005 A byte SHALL transfer on rx when rx_valid && rx_ready, and on tx when tx_valid && tx_ready.
REQ-006 Frame format SHALL be: command byte, then 4 address bytes MSB first; a write command is followed by 4 data bytes MSB first.
REQ-007 Commands SHALL be: 0x57 write, 0x52 read; any other command byte is invalid.
REQ-008 The FSM states SHALL be IDLE, ADDR, DATA, BUS_WR, BUS_RD, RD_WAIT, TX_RESP.
REQ-009 rx_ready SHALL be 1 only in IDLE, ADDR and DATA.
REQ-010 In IDLE, a command byte of 0x57 or 0x52 SHALL go to ADDR with the byte counter cleared.
REQ-011 In IDLE, an invalid command byte SHALL load response 0x3F, length 1, and go to TX_RESP with no bus access.
REQ-012 In ADDR, each byte SHALL shift into the address register.
REQ-013 On the 4th address byte, ADDR SHALL go to DATA for a write and to BUS_RD for a read.
REQ-014 In DATA, each byte SHALL shift into the write-data register; the 4th byte goes to BUS_WR.
REQ-015 In BUS_WR, bus_wr_en SHALL be 1 for exactly one cycle with bus_addr and bus_wr_data stable; the FSM then loads response 0x4B, length 1, and goes to TX_RESP.
REQ-016 In BUS_RD, bus_rd_en SHALL be 1 for exactly one cycle.
REQ-017 In RD_WAIT, bus_rd_data SHALL be captured into the response register, length 4, and the FSM goes to TX_RESP.
REQ-018 In TX_RESP, tx_valid SHALL be 1 and tx_data SHALL be the current response byte, MSB first, held stable until accepted.
REQ-019 After the last response byte is accepted, TX_RESP SHALL return to IDLE.
REQ-020 bus_wr_en and bus_rd_en SHALL never be high together and SHALL be 0 outside BUS_WR and BUS_RD.
REQ-021 bus_addr and bus_wr_data SHALL be registered and SHALL hold their last value between frames.
REQ-022 Shift-in SHALL be {reg[DATA_WIDTH-9:0], rx_data}; the byte counter is 2 bits and wraps 3->0 on the 4th byte.
REQ-023 A timeout counter SHALL clear on every accepted byte and increment each cycle in ADDR or DATA.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL abort to IDLE with no bus strobe and no response.
REQ-025 The timeout counter SHALL not run in IDLE, BUS_*, RD_WAIT or TX_RESP; tx back-pressure never times out.
REQ-026 Read-to-tx latency SHALL be: 4th address byte accepted at cycle N -> bus_rd_en at N+1 -> capture at N+2 -> tx_valid at N+3.
REQ-027 Write latency SHALL be: 4th data byte accepted at cycle N -> bus_wr_en at N+1 -> tx_valid at N+2.

Reset
REQ-028 While rst is 1 at a clk edge, the state SHALL become IDLE, counters clear, and tx_valid, bus_wr_en, bus_rd_en and busy are 0.
REQ-029 At the same reset edge, bus_addr, bus_wr_data, tx_data and the response register SHALL become 0, and rx_ready is 1 on the next cycle.
REQ-030 Reset mid-frame or mid-response SHALL discard the frame; no further strobe or tx byte is issued for that frame.

Verification
REQ-031 Write: bytes 57 00 00 00 10 DE AD BE EF -> one bus_wr_en cycle with addr 0x10 and data 0xDEADBEEF, then tx 0x4B.
REQ-032 Read: bytes 52 00 00 00 10 with bus_rd_data 0x12345678 -> one bus_rd_en cycle at addr 0x10, then tx 12 34 56 78, with latency per REQ-026.
REQ-033 Invalid command 0xAA -> tx 0x3F only, no bus strobe, then a following valid write frame completes normally.
REQ-034 tx_ready held 0 for 20 cycles during a read response -> tx_data stable and tx_valid held, with no timeout or byte loss.
REQ-035 With TIMEOUT_CYCLES=16, bytes 57 00 00 followed by silence -> return to IDLE after 16 cycles, no strobe, no tx.
REQ-036 rst asserted during the 2nd data byte of a write -> no bus_wr_en, and all outputs at reset values the next cycle.
